wb_fifo_mailbox: RTL and testbench
==================================

// Module: wb_fifo_mailbox
// PURPOSE
//  Wishbone classic slave on the bus arbiter's single slave port. Bus writes
//  push words into an internal FIFO; a valid/ready stream drains it to a
//  downstream consumer. Status/control registers give fill level, overflow
//  and flush. Clocked on posedge clk only.
// PARAMETERS
//  ADDRESS_WIDTH  32  width of sAdrI
//  DATA_WIDTH     32  width of bus and FIFO words; must be >= DEPTH_WIDTH+9
//  DEPTH_WIDTH    4   FIFO depth = 1<<DEPTH_WIDTH entries (default 16)
// PORTS
//  clk       in   1              clock, all state on rising edge
//  rstN      in   1              reset, asynchronous assert, active-low
//  sCycI     in   1              bus cycle
//  sStbI     in   1              strobe
//  sWeI      in   1              1 = write
//  sAdrI     in   ADDRESS_WIDTH  sAdrI[1:0] selects register, rest ignored
//  sDatI     in   DATA_WIDTH     write data
//  sDatO     out  DATA_WIDTH     read data, valid while sAckO=1
//  sAckO     out  1              one-cycle acknowledge
//  outValid  out  1              FIFO not empty
//  outData   out  DATA_WIDTH     FIFO head word
//  outReady  in   1              consumer accepts head when outValid=1
//  irq       out  1              only with WB_FIFO_IRQ_EN
// BEHAVIOUR
//  Reset (rstN=0, async): FIFO empty, pointers 0, overflow=0, sAckO=0,
//   sDatO=0, outValid=0, threshold=0, irq=0. Reset mid-transfer aborts it:
//   no ack, no push.
//  Register map (sAdrI[1:0]):
//   0 DATA    W: push sDatI. R: returns 0.
//   1 STATUS  R: bit0 empty, bit1 full, bit2 overflow,
//             bits[8+DEPTH_WIDTH:8] count (0..DEPTH); others 0.
//             W: bit2=1 clears overflow; other bits ignored.
//   2 CONTROL W: bit0=1 flushes FIFO. R: returns 0.
//   3 THRESH  see CONFIGURATION.
//  Handshake: request = sCycI & sStbI & !sAckO sampled on an edge; sAckO is
//   1 the following cycle for exactly one cycle. The write side effect
//   (push/clear/flush) is committed on the edge that raises sAckO. sDatO is
//   registered with sAckO; 0 when sAckO=0. A request held through the ack
//   cycle is not re-accepted there: max rate one transfer per 2 cycles.
//   Every request is acked (no err/retry).
//  FIFO: circular buffer with DEPTH_WIDTH+1-bit pointers; full when pointers
//   differ only in MSB; wrap-around is natural modulo overflow.
//   outValid = !empty; outData = mem[rdPtr] (combinational from registers).
//   Pop on outValid & outReady.
//  Boundary rules (same edge):
//   push while full, no pop: word dropped, overflow set (sticky), still acked.
//   push + pop while full: both occur, count stays DEPTH, no overflow.
//   push + pop while empty: push only (outValid was 0); count 0 -> 1.
//   flush + pop or flush + push: flush wins; count -> 0, push not counted
//    as overflow.
//   overflow set and clear on same edge: clear wins.
// CONFIGURATION
//  WB_FIFO_IRQ_EN defined: port irq exists; offset 3 is R/W threshold
//   register (low DEPTH_WIDTH+1 bits, others read 0); irq registered,
//   irq=1 the cycle after count >= threshold and threshold != 0, or
//   overflow=1.
//  Not defined: no irq port; offset 3 reads 0, writes ignored (still acked).
// TESTING
//  1 Reset then read STATUS -> sAckO one cycle after stb, sDatO=0x0000_0001.
//  2 Write DATA 0xA5, 0x5A; outReady=0 -> STATUS=0x0000_0200, outData=0xA5;
//    outReady=1 two cycles -> 0xA5 then 0x5A delivered, outValid falls.
//  3 Fill 16 words, push 0xDEAD -> STATUS=0x0000_1006, 0xDEAD never on
//    outData; write STATUS 0x4 -> overflow clears (0x0000_1002).
//  4 Full FIFO, push 0x77 with outReady=1 same edge -> count stays 16,
//    overflow=0, 0x77 appears last after 15 further pops.
//  5 5 words queued, write CONTROL 0x1 while outReady=1 -> outValid=0 next
//    cycle, STATUS=0x0000_0001; assert rstN=0 mid-ack -> sAckO drops at once.
//  6 WB_FIFO_IRQ_EN: THRESH=3, push 3 words -> irq=1 cycle after 3rd push;
//    pop one -> irq=0 next cycle.

Source files
------------

// File: rtl/wb_fifo_mailbox_if.sv
// rtl/wb_fifo_mailbox_if.sv - Wishbone classic slave bus plus drain stream for the FIFO mailbox
interface wb_fifo_mailbox_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     sCycI;
  logic                     sStbI;
  logic                     sWeI;
  logic [ADDRESS_WIDTH-1:0] sAdrI;
  logic [DATA_WIDTH-1:0]    sDatI;
  logic [DATA_WIDTH-1:0]    sDatO;
  logic                     sAckO;
  logic                     outValid;
  logic [DATA_WIDTH-1:0]    outData;
  logic                     outReady;

  modport master (
    output sCycI, sStbI, sWeI, sAdrI, sDatI, outReady,
    input  sDatO, sAckO, outValid, outData
  );

  modport slave (
    input  sCycI, sStbI, sWeI, sAdrI, sDatI, outReady,
    output sDatO, sAckO, outValid, outData
  );
endinterface

// File: rtl/wb_fifo_mailbox.sv
// rtl/wb_fifo_mailbox.sv - Wishbone write-push FIFO mailbox drained by a valid/ready stream
// Optional threshold register and irq output enabled by WB_FIFO_IRQ_EN.
module wb_fifo_mailbox #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH_WIDTH   = 4
) (
  input  logic              clk,
  input  logic              rstN,
  wb_fifo_mailbox_if.slave  bus
`ifdef WB_FIFO_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int CW    = DEPTH_WIDTH + 1;
  localparam int DEPTH = 1 << DEPTH_WIDTH;

  localparam logic [1:0] ADR_DATA    = 2'd0;
  localparam logic [1:0] ADR_STATUS  = 2'd1;
  localparam logic [1:0] ADR_CONTROL = 2'd2;
  localparam logic [1:0] ADR_THRESH  = 2'd3;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;

  logic                  req, wr_req;
  logic [1:0]            adr;
  logic                  empty, full, pop;
  logic                  push_req, flush, ovf_clr, do_push, ovf_set;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] status;
  logic                  unused_adr;

  assign unused_adr = ^bus.sAdrI[ADDRESS_WIDTH-1:2];
  assign adr        = bus.sAdrI[1:0];

  // The ack cycle blocks re-acceptance so a held strobe gives one transfer per two cycles.
  assign req    = bus.sCycI & bus.sStbI & ~ack_q;
  assign wr_req = req & bus.sWeI;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {DEPTH_WIDTH{1'b0}}};
  assign pop   = ~empty & bus.outReady;

  assign push_req = wr_req & (adr == ADR_DATA);
  assign flush    = wr_req & (adr == ADR_CONTROL) & bus.sDatI[0];
  assign ovf_clr  = wr_req & (adr == ADR_STATUS) & bus.sDatI[2];
  // A pop on the same edge frees the slot, so a push into a full FIFO is only lost without one.
  assign do_push  = push_req & ~flush & (~full | pop);
  assign ovf_set  = push_req & ~flush & full & ~pop;

  assign bus.outValid = ~empty;
  assign bus.outData  = mem_q[rd_ptr_q[DEPTH_WIDTH-1:0]];
  assign bus.sAckO    = ack_q;
  assign bus.sDatO    = dat_q;

  always_comb begin
    status         = '0;
    status[0]      = empty;
    status[1]      = full;
    status[2]      = ovf_q;
    status[8 +: CW] = count;
  end

`ifdef WB_FIFO_IRQ_EN
  logic [CW-1:0] thresh_q, thresh_d;
  logic          irq_q, irq_d;

  always_comb begin
    thresh_d = thresh_q;
    if (wr_req && adr == ADR_THRESH) begin
      thresh_d = bus.sDatI[CW-1:0];
    end
    irq_d = ((thresh_q != '0) && (count >= thresh_q)) || ovf_q;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    ack_d    = req;
    dat_d    = '0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;

    if (req && !bus.sWeI) begin
      case (adr)
        ADR_STATUS: dat_d = status;
`ifdef WB_FIFO_IRQ_EN
        ADR_THRESH: dat_d = {{(DATA_WIDTH-CW){1'b0}}, thresh_q};
`endif
        default:    dat_d = '0;
      endcase
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (ovf_clr)      ovf_d = 1'b0;
    else if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  // Storage carries no reset; entries are only observable once the write pointer has passed them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[DEPTH_WIDTH-1:0]] <= bus.sDatI;
    end
  end

endmodule

// File: tb/tb_wb_fifo_mailbox.sv
// tb/tb_wb_fifo_mailbox.sv - directed self-checking bench for wb_fifo_mailbox
module tb_wb_fifo_mailbox;

  logic clk;
  logic rstN;
  int   vectors;
  int   miscompares;

  wb_fifo_mailbox_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bi ();

`ifdef WB_FIFO_IRQ_EN
  logic irq;
  wb_fifo_mailbox #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WIDTH(4)) dut (
    .clk(clk), .rstN(rstN), .bus(bi), .irq(irq)
  );
`else
  wb_fifo_mailbox #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WIDTH(4)) dut (
    .clk(clk), .rstN(rstN), .bus(bi)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_xfer(input logic we, input logic [1:0] adr, input logic [31:0] d,
                          output logic ack, output logic [31:0] rd);
    bi.sCycI = 1'b1;
    bi.sStbI = 1'b1;
    bi.sWeI  = we;
    bi.sAdrI = {30'd0, adr};
    bi.sDatI = d;
    @(posedge clk); #1;
    ack = bi.sAckO;
    rd  = bi.sDatO;
    bi.sCycI = 1'b0;
    bi.sStbI = 1'b0;
    bi.sWeI  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic ack;
    logic [31:0] rd;
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bi.sAckO !== 1'b0 || bi.sDatO !== 32'h0 || bi.outValid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: ack=%b dat=%h valid=%b want 0 0 0", bi.sAckO, bi.sDatO, bi.outValid);
    end
    rstN = 1'b1;
    @(posedge clk); #1;
    bus_xfer(1'b0, 2'd1, 32'h0, ack, rd);
    vectors++;
    if (ack !== 1'b1 || rd !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL reset_status: ack=%b dat=%h want 1 00000001", ack, rd);
    end
  endtask

  task automatic test_regs();
    logic ack;
    logic [31:0] rd;
    bus_xfer(1'b0, 2'd0, 32'h0, ack, rd);
    vectors++;
    if (ack !== 1'b1 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL read_data_reg: ack=%b dat=%h want 1 0", ack, rd);
    end
    bus_xfer(1'b0, 2'd2, 32'h0, ack, rd);
    vectors++;
    if (ack !== 1'b1 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL read_control_reg: ack=%b dat=%h want 1 0", ack, rd);
    end
`ifndef WB_FIFO_IRQ_EN
    bus_xfer(1'b1, 2'd3, 32'h7, ack, rd);
    vectors++;
    if (ack !== 1'b1) begin
      miscompares++;
      $display("FAIL write_thresh_ack: ack=%b want 1", ack);
    end
    bus_xfer(1'b0, 2'd3, 32'h0, ack, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL read_thresh_disabled: dat=%h want 0", rd);
    end
`endif
  endtask

  task automatic test_push_pop();
    logic ack;
    logic [31:0] rd;
    bi.outReady = 1'b0;
    bus_xfer(1'b1, 2'd0, 32'hA5, ack, rd);
    bus_xfer(1'b1, 2'd0, 32'h5A, ack, rd);
    bus_xfer(1'b0, 2'd1, 32'h0, ack, rd);
    vectors++;
    if (rd !== 32'h0000_0200 || bi.outData !== 32'hA5) begin
      miscompares++;
      $display("FAIL two_words_status: status=%h head=%h want 00000200 000000a5", rd, bi.outData);
    end
    bi.outReady = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bi.outValid !== 1'b1 || bi.outData !== 32'h5A) begin
      miscompares++;
      $display("FAIL second_head: valid=%b head=%h want 1 0000005a", bi.outValid, bi.outData);
    end
    @(posedge clk); #1;
    bi.outReady = 1'b0;
    vectors++;
    if (bi.outValid !== 1'b0) begin
      miscompares++;
      $display("FAIL drained_valid: valid=%b want 0", bi.outValid);
    end
  endtask

  task automatic test_overflow();
    logic ack;
    logic [31:0] rd;
    for (int i = 0; i < 16; i++) bus_xfer(1'b1, 2'd0, 32'h100 + i, ack, rd);
    bus_xfer(1'b0, 2'd1, 32'h0, ack, rd);
    vectors++;
    if (rd !== 32'h0000_1002) begin
      miscompares++;
      $display("FAIL full_status: status=%h want 00001002", rd);
    end
    bus_xfer(1'b1, 2'd0, 32'hDEAD, ack, rd);
    vectors++;
    if (ack !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_push_ack: ack=%b want 1", ack);
    end
    bus_xfer(1'b0, 2'd1, 32'h0, ack, rd);
    vectors++;
    if (rd !== 32'h0000_1006 || bi.outData !== 32'h100) begin
      miscompares++;
      $display("FAIL overflow_status: status=%h head=%h want 00001006 00000100", rd, bi.outData);
    end
    bus_xfer(1'b1, 2'd1, 32'h4, ack, rd);
    bus_xfer(1'b0, 2'd1, 32'h0, ack, rd);
    vectors++;
    if (rd !== 32'h0000_1002) begin
      miscompares++;
      $display("FAIL overflow_clear: status=%h want 00001002", rd);
    end
  endtask

  task automatic test_full_push_pop();
    logic ack;
    logic [31:0] rd;
    bi.sCycI = 1'b1; bi.sStbI = 1'b1; bi.sWeI = 1'b1;
    bi.sAdrI = 32'd0; bi.sDatI = 32'h77;
    bi.outReady = 1'b1;
    @(posedge clk); #1;
    bi.outReady = 1'b0;
    bi.sCycI = 1'b0; bi.sStbI = 1'b0; bi.sWeI = 1'b0;
    vectors++;
    if (bi.sAckO !== 1'b1) begin
      miscompares++;
      $display("FAIL full_push_pop_ack: ack=%b want 1", bi.sAckO);
    end
    @(posedge clk); #1;
    bus_xfer(1'b0, 2'd1, 32'h0, ack, rd);
    vectors++;
    if (rd !== 32'h0000_1002) begin
      miscompares++;
      $display("FAIL full_push_pop_status: status=%h want 00001002", rd);
    end
    bi.outReady = 1'b1;
    for (int i = 1; i < 16; i++) begin
      vectors++;
      if (bi.outData !== 32'h100 + i) begin
        miscompares++;
        $display("FAIL drain_order[%0d]: head=%h want %h", i, bi.outData, 32'h100 + i);
      end
      @(posedge clk); #1;
    end
    bi.outReady = 1'b0;
    vectors++;
    if (bi.outValid !== 1'b1 || bi.outData !== 32'h77) begin
      miscompares++;
      $display("FAIL last_word: valid=%b head=%h want 1 00000077", bi.outValid, bi.outData);
    end
    bi.outReady = 1'b1;
    @(posedge clk); #1;
    bi.outReady = 1'b0;
    vectors++;
    if (bi.outValid !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_after_last: valid=%b want 0", bi.outValid);
    end
  endtask

  task automatic test_back_to_back();
    logic ack;
    logic [31:0] rd;
    logic [3:0] acks;
    bi.sCycI = 1'b1; bi.sStbI = 1'b1; bi.sWeI = 1'b1;
    bi.sAdrI = 32'd0; bi.sDatI = 32'h11;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      acks[i] = bi.sAckO;
    end
    bi.sCycI = 1'b0; bi.sStbI = 1'b0; bi.sWeI = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (acks !== 4'b0101) begin
      miscompares++;
      $display("FAIL held_strobe_acks: acks=%b want 0101", acks);
    end
    bus_xfer(1'b0, 2'd1, 32'h0, ack, rd);
    vectors++;
    if (rd !== 32'h0000_0200) begin
      miscompares++;
      $display("FAIL held_strobe_count: status=%h want 00000200", rd);
    end
    bi.outReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bi.outReady = 1'b0;
  endtask

  task automatic test_flush_reset();
    logic ack;
    logic [31:0] rd;
    for (int i = 1; i <= 5; i++) bus_xfer(1'b1, 2'd0, i, ack, rd);
    bi.sCycI = 1'b1; bi.sStbI = 1'b1; bi.sWeI = 1'b1;
    bi.sAdrI = 32'd2; bi.sDatI = 32'h1;
    bi.outReady = 1'b1;
    @(posedge clk); #1;
    bi.outReady = 1'b0;
    bi.sCycI = 1'b0; bi.sStbI = 1'b0; bi.sWeI = 1'b0;
    vectors++;
    if (bi.outValid !== 1'b0 || bi.sAckO !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_valid: valid=%b ack=%b want 0 1", bi.outValid, bi.sAckO);
    end
    @(posedge clk); #1;
    bus_xfer(1'b0, 2'd1, 32'h0, ack, rd);
    vectors++;
    if (rd !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL flush_status: status=%h want 00000001", rd);
    end
    bi.sCycI = 1'b1; bi.sStbI = 1'b1; bi.sWeI = 1'b1;
    bi.sAdrI = 32'd0; bi.sDatI = 32'h99;
    @(posedge clk); #1;
    vectors++;
    if (bi.sAckO !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_ack: ack=%b want 1", bi.sAckO);
    end
    rstN = 1'b0;
    #1;
    vectors++;
    if (bi.sAckO !== 1'b0 || bi.outValid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_ack: ack=%b valid=%b want 0 0", bi.sAckO, bi.outValid);
    end
    bi.sCycI = 1'b0; bi.sStbI = 1'b0; bi.sWeI = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    bus_xfer(1'b0, 2'd1, 32'h0, ack, rd);
    vectors++;
    if (rd !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL post_reset_status: status=%h want 00000001", rd);
    end
  endtask

`ifdef WB_FIFO_IRQ_EN
  task automatic test_irq();
    logic ack;
    logic [31:0] rd;
    bus_xfer(1'b1, 2'd3, 32'hFFFF_FFE3, ack, rd);
    bus_xfer(1'b0, 2'd3, 32'h0, ack, rd);
    vectors++;
    if (rd !== 32'h0000_0003) begin
      miscompares++;
      $display("FAIL thresh_readback: dat=%h want 00000003", rd);
    end
    bus_xfer(1'b1, 2'd0, 32'h1, ack, rd);
    bus_xfer(1'b1, 2'd0, 32'h2, ack, rd);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_below_thresh: irq=%b want 0", irq);
    end
    bus_xfer(1'b1, 2'd0, 32'h3, ack, rd);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_at_thresh: irq=%b want 1", irq);
    end
    bi.outReady = 1'b1;
    @(posedge clk); #1;
    bi.outReady = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_after_pop: irq=%b want 0", irq);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstN        = 1'b0;
    bi.sCycI    = 1'b0;
    bi.sStbI    = 1'b0;
    bi.sWeI     = 1'b0;
    bi.sAdrI    = '0;
    bi.sDatI    = '0;
    bi.outReady = 1'b0;
    test_reset();
    test_regs();
    test_push_pop();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_flush_reset();
`ifdef WB_FIFO_IRQ_EN
    test_irq();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
